regwrite_arbiter: RTL and testbench
===================================

REGWRITE_ARBITER -- requirements
Module: regwrite_arbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- FIFO_DEPTH, 2, entries in the deferred-write FIFO (power of 2, >= 2)
- STARVE_LIMIT, 4, consecutive pipeline-won cycles before stall_req is raised (1..7)

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on rising edge
- rst, in, 1, reset; synchronous, active-high
- wb_reg_write, in, 1, writeback-stage write enable (no backpressure)
- wb_write_register, in, 5, writeback-stage destination register
- wb_write_data, in, 32, writeback-stage write data
- mdu_valid, in, 1, multi-cycle unit write request
- mdu_reg, in, 5, multi-cycle unit destination register
- mdu_data, in, 32, multi-cycle unit write data
- mdu_ready, out, 1, FIFO can accept a request this cycle
- rf_we, out, 1, register-file write enable (registered)
- rf_waddr, out, 5, register-file write address (registered)
- rf_wdata, out, 32, register-file write data (registered)
- stall_req, out, 1, request the pipeline to insert one writeback bubble
- fifo_count, out, log2(FIFO_DEPTH)+1, current FIFO occupancy

Function
REQ-003 The register-file write port SHALL be shared between the writeback stage (priority) and the FIFO head (deferred).
REQ-004 A writeback write SHALL be valid when wb_reg_write=1 and wb_write_register!=0.
REQ-005 A request SHALL be accepted when mdu_valid=1 and mdu_ready=1.
REQ-006 mdu_ready SHALL be 1 exactly when fifo_count < FIFO_DEPTH, using the registered count, independent of any same-cycle pop.
REQ-007 An accepted request with mdu_reg=0 SHALL be consumed without enqueue, with fifo_count unchanged.
REQ-008 An accepted request with mdu_reg!=0 SHALL be enqueued at the tail.
REQ-009 Port selection each cycle:
- valid writeback write: it wins and the FIFO is not popped.
- otherwise, FIFO non-empty: the head is popped and wins.
- otherwise: no winner.
REQ-010 On the next rising edge:
- with a winner: rf_we=1 and rf_waddr/rf_wdata = winner's register/data (latency 1 cycle).
- without a winner: rf_we=0, and rf_waddr/rf_wdata hold their previous values.
REQ-011 A push and a pop in the same cycle SHALL both take effect, leaving fifo_count unchanged.
REQ-012 A request accepted in cycle N SHALL NOT be popped before cycle N+1 (no FIFO bypass).
REQ-013 Read and write pointers SHALL wrap modulo FIFO_DEPTH, and the FIFO SHALL preserve order.
REQ-014 starve_cnt, a 3-bit internal counter, SHALL:
- increment, saturating at STARVE_LIMIT, in each cycle where the FIFO is non-empty and a writeback write wins;
- clear on any pop or whenever the FIFO is empty.
REQ-015 stall_req SHALL equal (starve_cnt == STARVE_LIMIT), combinationally from the registered counter.
REQ-016 If wb_reg_write=1 while stall_req=1 (protocol violation), the writeback write SHALL still win and no data SHALL be lost.
REQ-017 When the writeback and FIFO head target the same register, they SHALL be written in arbitration order, with no merging.

Reset
REQ-018 While rst=1 at a rising edge, the block SHALL set:
- rf_we=0, rf_waddr=0, rf_wdata=0
- FIFO pointers=0, fifo_count=0, starve_cnt=0
REQ-019 During and after reset: mdu_ready=1 and stall_req=0 from the first cycle after reset.
REQ-020 A reset asserted mid-operation SHALL discard all FIFO contents, and no deferred write SHALL appear on rf_we afterwards.
REQ-021 Requests presented in a cycle with rst=1 SHALL NOT be accepted.

Verification
REQ-022 Writeback only: wb_reg_write=1, reg 8, data 0x12345678 -> next cycle rf_we=1, rf_waddr=8, rf_wdata=0x12345678, fifo_count=0.
REQ-023 Conflict: in the same cycle, writeback (reg 3, 0xA) and mdu request (reg 5, 0xB):
- next cycle: rf_waddr=3, fifo_count=1
- following idle cycle: rf_waddr=5, rf_wdata=0xB, fifo_count=0
REQ-024 Full FIFO and wrap:
- 2 mdu pushes under continuous writeback -> mdu_ready=0
- third request held (no accept)
- drain: entries written in push order
- 5 further push/pop rounds: order preserved across pointer wrap
REQ-025 Starvation: FIFO holds 1 entry with continuous writeback writes -> stall_req=1 after 4 cycles; pipeline bubble -> head written, stall_req=0 the next cycle.
REQ-026 Register 0:
- writeback to reg 0 -> rf_we=0 and a waiting FIFO head is popped instead
- mdu request to reg 0 -> accepted, fifo_count stays 0
REQ-027 Reset mid-operation: with fifo_count=2, rst=1 for one cycle -> fifo_count=0, rf_we=0, and no deferred write for 10 following idle cycles.

Source files
------------

// File: rtl/regwrite_arbiter.sv
// Shares the register-file write port between writeback (priority) and a deferred FIFO; 1-cycle registered write.
// Backpressure: mdu_ready drops when the FIFO is full; stall_req asks the pipeline for a bubble when the head starves.
module regwrite_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wb_reg_write,
    input  logic [4:0]                    wb_write_register,
    input  logic [31:0]                   wb_write_data,
    input  logic                          mdu_valid,
    input  logic [4:0]                    mdu_reg,
    input  logic [31:0]                   mdu_data,
    output logic                          mdu_ready,
    output logic                          rf_we,
    output logic [4:0]                    rf_waddr,
    output logic [31:0]                   rf_wdata,
    output logic                          stall_req,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] dat;
    } wr_ent_t;

    wr_ent_t         r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [2:0]      r_starve_cnt;
    logic            r_rf_we;
    logic [4:0]      r_rf_waddr;
    logic [31:0]     r_rf_wdata;

    logic            w_wb_vld;
    logic            w_empty;
    logic            w_accept;
    logic            w_push;
    logic            w_pop;
    wr_ent_t         w_head;

    assign w_wb_vld  = wb_reg_write && (wb_write_register != 5'd0);
    assign w_empty   = (r_count == '0);
    assign mdu_ready = (r_count < CW'(FIFO_DEPTH));
    assign w_accept  = mdu_valid && mdu_ready && !rst;
    assign w_push    = w_accept && (mdu_reg != 5'd0);
    // Pop decision uses the registered count only, so a same-cycle push never bypasses.
    assign w_pop     = !w_wb_vld && !w_empty;
    assign w_head    = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= '{addr: mdu_reg, dat: mdu_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (w_pop || w_empty) begin
            r_starve_cnt <= '0;
        end else if (w_wb_vld && (r_starve_cnt != 3'(STARVE_LIMIT))) begin
            r_starve_cnt <= r_starve_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else if (w_wb_vld) begin
            r_rf_we    <= 1'b1;
            r_rf_waddr <= wb_write_register;
            r_rf_wdata <= wb_write_data;
        end else if (w_pop) begin
            r_rf_we    <= 1'b1;
            r_rf_waddr <= w_head.addr;
            r_rf_wdata <= w_head.dat;
        end else begin
            r_rf_we    <= 1'b0;
        end
    end

    assign stall_req  = (r_starve_cnt == 3'(STARVE_LIMIT));
    assign rf_we      = r_rf_we;
    assign rf_waddr   = r_rf_waddr;
    assign rf_wdata   = r_rf_wdata;
    assign fifo_count = r_count;

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Directed scenarios plus randomized traffic, checked against a queue-based model of the write-port rules.
module tb_regwrite_arbiter;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_reg_write;
    logic [4:0]    wb_write_register;
    logic [31:0]   wb_write_data;
    logic          mdu_valid;
    logic [4:0]    mdu_reg;
    logic [31:0]   mdu_data;
    logic          mdu_ready;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [31:0]   rf_wdata;
    logic          stall_req;
    logic [CW-1:0] fifo_count;

    regwrite_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk               (clk),
        .rst               (rst),
        .wb_reg_write      (wb_reg_write),
        .wb_write_register (wb_write_register),
        .wb_write_data     (wb_write_data),
        .mdu_valid         (mdu_valid),
        .mdu_reg           (mdu_reg),
        .mdu_data          (mdu_data),
        .mdu_ready         (mdu_ready),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .stall_req         (stall_req),
        .fifo_count        (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    int          starve  = 0;
    bit          m_known = 1'b0;
    bit          m_we    = 1'b0;
    logic [4:0]  m_addr  = '0;
    logic [31:0] m_data  = '0;
    int          n_checks = 0;
    int          n_err    = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check the combinational outputs mid-cycle,
    // advance the model, then check the registered outputs just after the edge.
    task automatic cycle(input bit wbw, input logic [4:0] wbr, input logic [31:0] wbd,
                         input bit mv, input logic [4:0] mr, input logic [31:0] md, input bit r);
        bit   acc;
        bit   wbv;
        ent_t e;
        wb_reg_write      = wbw;
        wb_write_register = wbr;
        wb_write_data     = wbd;
        mdu_valid         = mv;
        mdu_reg           = mr;
        mdu_data          = md;
        rst               = r;
        #4;
        if (m_known) begin
            chk("mdu_ready", 64'(mdu_ready), 64'(q.size() < DEPTH));
            chk("stall_req", 64'(stall_req), 64'(starve == LIMIT));
        end
        if (r) begin
            q.delete();
            starve = 0;
            m_we   = 1'b0;
            m_addr = '0;
            m_data = '0;
        end else begin
            acc = mv && (q.size() < DEPTH);
            wbv = wbw && (wbr != 5'd0);
            if (wbv) begin
                m_we   = 1'b1;
                m_addr = wbr;
                m_data = wbd;
                if (q.size() > 0) starve = (starve + 1 > LIMIT) ? LIMIT : starve + 1;
                else              starve = 0;
            end else if (q.size() > 0) begin
                e      = q.pop_front();
                m_we   = 1'b1;
                m_addr = e.r;
                m_data = e.d;
                starve = 0;
            end else begin
                m_we   = 1'b0;
                starve = 0;
            end
            if (acc && (mr != 5'd0)) begin
                e.r = mr;
                e.d = md;
                q.push_back(e);
            end
        end
        m_known = 1'b1;
        @(posedge clk);
        #1;
        chk("rf_we",      64'(rf_we),      64'(m_we));
        chk("rf_waddr",   64'(rf_waddr),   64'(m_addr));
        chk("rf_wdata",   64'(rf_wdata),   64'(m_data));
        chk("fifo_count", 64'(fifo_count), 64'(q.size()));
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    initial begin
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'd1, 1'b1);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'd1, 1'b1);
        chk("rst_ready", 64'(mdu_ready), 64'd1);
        chk("rst_stall", 64'(stall_req), 64'd0);
        chk("rst_cnt",   64'(fifo_count), 64'd0);
        chk("rst_we",    64'(rf_we), 64'd0);

        // Writeback only
        cycle(1'b1, 5'd8, 32'h12345678, 1'b0, 5'd0, 32'd0, 1'b0);
        chk("wb_we",   64'(rf_we), 64'd1);
        chk("wb_addr", 64'(rf_waddr), 64'd8);
        chk("wb_data", 64'(rf_wdata), 64'h12345678);

        // Conflict: writeback wins, request deferred one cycle
        cycle(1'b1, 5'd3, 32'hA, 1'b1, 5'd5, 32'hB, 1'b0);
        chk("conf_addr", 64'(rf_waddr), 64'd3);
        chk("conf_cnt",  64'(fifo_count), 64'd1);
        idle();
        chk("conf_pop_addr", 64'(rf_waddr), 64'd5);
        chk("conf_pop_data", 64'(rf_wdata), 64'hB);
        chk("conf_pop_cnt",  64'(fifo_count), 64'd0);

        // Fill, hold a third request, drain in order, then wrap the pointers
        cycle(1'b1, 5'd1, 32'h100, 1'b1, 5'd10, 32'h200, 1'b0);
        cycle(1'b1, 5'd2, 32'h101, 1'b1, 5'd11, 32'h201, 1'b0);
        chk("full_ready", 64'(mdu_ready), 64'd0);
        cycle(1'b1, 5'd3, 32'h102, 1'b1, 5'd12, 32'h202, 1'b0);
        chk("full_held_cnt", 64'(fifo_count), 64'd2);
        idle();
        chk("drain0_addr", 64'(rf_waddr), 64'd10);
        idle();
        chk("drain1_addr", 64'(rf_waddr), 64'd11);
        idle();
        chk("drain_done_we", 64'(rf_we), 64'd0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'(20 + i), 32'(i + 32'h300), 1'b0);
        end
        idle();
        chk("wrap_last_addr", 64'(rf_waddr), 64'd24);
        idle();

        // Starvation and relief by a bubble
        cycle(1'b1, 5'd4, 32'h1, 1'b1, 5'd7, 32'h77, 1'b0);
        for (int i = 0; i < LIMIT; i++) begin
            cycle(1'b1, 5'd4, 32'(i), 1'b0, 5'd0, 32'd0, 1'b0);
        end
        chk("starve_hi", 64'(stall_req), 64'd1);
        cycle(1'b1, 5'd4, 32'h9, 1'b0, 5'd0, 32'd0, 1'b0);
        idle();
        chk("starve_pop_addr", 64'(rf_waddr), 64'd7);
        chk("starve_lo", 64'(stall_req), 64'd0);

        // Register 0 handling
        cycle(1'b1, 5'd6, 32'h1, 1'b1, 5'd9, 32'h99, 1'b0);
        cycle(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0, 1'b0);
        chk("r0_pop_we",   64'(rf_we), 64'd1);
        chk("r0_pop_addr", 64'(rf_waddr), 64'd9);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55, 1'b0);
        chk("r0_mdu_cnt", 64'(fifo_count), 64'd0);
        chk("r0_mdu_we",  64'(rf_we), 64'd0);

        // Reset mid-operation discards the backlog
        cycle(1'b1, 5'd1, 32'h1, 1'b1, 5'd13, 32'h13, 1'b0);
        cycle(1'b1, 5'd1, 32'h2, 1'b1, 5'd14, 32'h14, 1'b0);
        chk("pre_rst_cnt", 64'(fifo_count), 64'd2);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd15, 32'h15, 1'b1);
        chk("mid_rst_cnt", 64'(fifo_count), 64'd0);
        chk("mid_rst_we",  64'(rf_we), 64'd0);
        for (int i = 0; i < 10; i++) idle();

        // Randomized traffic, including writebacks that ignore stall_req
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 31)), $urandom(),
                  ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom(),
                  ($urandom_range(0, 299) == 0));
        end
        for (int i = 0; i < 4; i++) idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
